hart_sched: RTL

- Parametrised barrel-thread (hart) scheduler for the multithreaded core. It is the runtime successor to the fixed thread/pipe-depth settings.
- Each cycle it picks one ready hart, round-robin, and issues its ID into fetch. The ID then travels as a tag through a NUM_PIPE_STAGES-deep chain to writeback.
- It supports any thread count relative to depth, including fewer threads than stages. In that case it inserts bubbles rather than issuing a hart twice.
- It also supports per-hart enable and per-hart flush.

---
 rtl/hart_sched_pkg.sv | 49 ++++
 rtl/hart_tag_pipe.sv | 51 +++++
 rtl/hart_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hart_sched_pkg.sv
// Shared types and helpers for the barrel-thread hart scheduler.
// hart_tag_t is sized from the NUM_THREADS macro (default 16); instances must not exceed it.
`ifndef NUM_THREADS
`define NUM_THREADS 16
`endif
`ifndef NUM_PIPE_STAGES
`define NUM_PIPE_STAGES 16
`endif

package hart_sched_pkg;

    localparam int PKG_NUM_THREADS = `NUM_THREADS;
    localparam int PKG_TID_W       = (PKG_NUM_THREADS > 1) ? $clog2(PKG_NUM_THREADS) : 1;
    localparam int MAX_THREADS     = 32;
    localparam int PICK_W          = 5;

    typedef struct packed {
        logic                 valid;
        logic [PKG_TID_W-1:0] tid;
    } hart_tag_t;

    // Cyclic first-set search starting at ptr (inclusive) over the low n bits; returns {found, tid}.
    function automatic logic [PICK_W:0] rr_pick(input logic [MAX_THREADS-1:0] mask,
                                                input logic [PICK_W-1:0]      ptr,
                                                input int                     n);
        logic              found;
        logic [PICK_W-1:0] tid;
        int                idx;
        found = 1'b0;
        tid   = '0;
        for (int k = 0; k < MAX_THREADS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (!found && k < n && mask[idx[PICK_W-1:0]]) begin
                found = 1'b1;
                tid   = idx[PICK_W-1:0];
            end
        end
        return {found, tid};
    endfunction

    function automatic logic [PICK_W:0] popcount(input logic [MAX_THREADS-1:0] v);
        logic [PICK_W:0] c;
        c = '0;
        for (int k = 0; k < MAX_THREADS; k++) c = c + (PICK_W+1)'(v[k]);
        return c;
    endfunction

endpackage

// File: rtl/hart_tag_pipe.sv
// Free-running valid/tid shift chain from issue (stage 0) to writeback (last stage),
// with a tid-matched kill that clears every matching entry as it shifts.
module hart_tag_pipe
    import hart_sched_pkg::*;
#(
    parameter int NUM_PIPE_STAGES = 16,
    parameter int TID_W           = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [TID_W-1:0] in_tid,
    input  logic             kill,
    input  logic [TID_W-1:0] kill_tid,
    output logic             head_valid,
    output logic [TID_W-1:0] head_tid,
    output logic             tail_valid,
    output logic [TID_W-1:0] tail_tid,
    output logic             any_valid
);

    hart_tag_t              tag_p [NUM_PIPE_STAGES];
    logic [PKG_TID_W-1:0]   in_key;
    logic [PKG_TID_W-1:0]   kill_key;

    assign in_key   = PKG_TID_W'(in_tid);
    assign kill_key = PKG_TID_W'(kill_tid);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_PIPE_STAGES; k++) tag_p[k] <= '0;
        end else begin
            tag_p[0] <= '{valid: in_valid & ~(kill & (in_key == kill_key)), tid: in_key};
            for (int k = 1; k < NUM_PIPE_STAGES; k++) begin
                tag_p[k] <= '{valid: tag_p[k-1].valid & ~(kill & (tag_p[k-1].tid == kill_key)),
                              tid:   tag_p[k-1].tid};
            end
        end
    end

    assign head_valid = tag_p[0].valid;
    assign head_tid   = TID_W'(tag_p[0].tid);
    assign tail_valid = tag_p[NUM_PIPE_STAGES-1].valid;
    assign tail_tid   = TID_W'(tag_p[NUM_PIPE_STAGES-1].tid);

    always_comb begin
        any_valid = 1'b0;
        for (int k = 0; k < NUM_PIPE_STAGES; k++) any_valid = any_valid | tag_p[k].valid;
    end

endmodule

// File: rtl/hart_sched.sv
// Round-robin barrel-thread scheduler: issues one ready hart per cycle into a tag chain.
// Optional perf counters are built when HART_SCHED_PERF_CNT_EN is defined.
`ifndef NUM_THREADS
`define NUM_THREADS 16
`endif
`ifndef NUM_PIPE_STAGES
`define NUM_PIPE_STAGES 16
`endif

module hart_sched
    import hart_sched_pkg::*;
#(
    parameter  int NUM_THREADS     = `NUM_THREADS,
    parameter  int NUM_PIPE_STAGES = `NUM_PIPE_STAGES,
    localparam int TID_W           = $clog2(NUM_THREADS),
    localparam int CNT_W           = $clog2(NUM_THREADS + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_THREADS-1:0] thread_en_i,
    input  logic                   flush_i,
    input  logic [TID_W-1:0]       flush_tid_i,
    output logic                   fetch_valid_o,
    output logic [TID_W-1:0]       fetch_tid_o,
    output logic                   wb_valid_o,
    output logic [TID_W-1:0]       wb_tid_o,
    output logic [NUM_THREADS-1:0] busy_o,
    output logic [CNT_W-1:0]       inflight_o,
    output logic                   idle_o
`ifdef HART_SCHED_PERF_CNT_EN
    ,
    input  logic                   perf_clr_i,
    output logic [31:0]            issue_cnt_o,
    output logic [31:0]            bubble_cnt_o
`endif
);

    logic [NUM_THREADS-1:0] busy_q;
    logic [NUM_THREADS-1:0] busy_nxt;
    logic [NUM_THREADS-1:0] retiring;
    logic [NUM_THREADS-1:0] flush_mask;
    logic [NUM_THREADS-1:0] ready;
    logic [TID_W-1:0]       rr_ptr;
    logic [TID_W-1:0]       ptr_nxt;
    logic [PICK_W:0]        pick;
    logic                   pick_found;
    logic [TID_W-1:0]       pick_tid;
    logic                   fetch_valid;
    logic [TID_W-1:0]       fetch_tid;
    logic                   wb_valid;
    logic [TID_W-1:0]       wb_tid;
    logic                   any_valid;

    // A retiring hart counts as free so it can reissue on its writeback cycle;
    // a hart being flushed sits out this cycle.
    always_comb begin
        retiring   = '0;
        flush_mask = '0;
        if (wb_valid) retiring[wb_tid] = 1'b1;
        if (flush_i)  flush_mask[flush_tid_i] = 1'b1;
        ready = thread_en_i & (~busy_q | retiring) & ~flush_mask;
    end

    assign pick       = rr_pick(MAX_THREADS'(ready), PICK_W'(rr_ptr), NUM_THREADS);
    assign pick_found = pick[PICK_W];
    assign pick_tid   = TID_W'(pick[PICK_W-1:0]);

    always_comb begin
        busy_nxt = busy_q & ~retiring & ~flush_mask;
        ptr_nxt  = rr_ptr;
        if (pick_found) begin
            busy_nxt[pick_tid] = 1'b1;
            ptr_nxt = (pick_tid == TID_W'(NUM_THREADS - 1)) ? '0 : pick_tid + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= '0;
            rr_ptr <= '0;
        end else begin
            busy_q <= busy_nxt;
            rr_ptr <= ptr_nxt;
        end
    end

    hart_tag_pipe #(
        .NUM_PIPE_STAGES (NUM_PIPE_STAGES),
        .TID_W           (TID_W)
    ) u_tag_pipe (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (pick_found),
        .in_tid     (pick_tid),
        .kill       (flush_i),
        .kill_tid   (flush_tid_i),
        .head_valid (fetch_valid),
        .head_tid   (fetch_tid),
        .tail_valid (wb_valid),
        .tail_tid   (wb_tid),
        .any_valid  (any_valid)
    );

    assign fetch_valid_o = fetch_valid;
    assign fetch_tid_o   = fetch_tid;
    assign wb_valid_o    = wb_valid;
    assign wb_tid_o      = wb_tid;
    assign busy_o        = busy_q;
    assign inflight_o    = CNT_W'(popcount(MAX_THREADS'(busy_q)));
    assign idle_o        = ~any_valid;

`ifdef HART_SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn || perf_clr_i) begin
            issue_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else if (fetch_valid) begin
            issue_cnt_o  <= issue_cnt_o + 32'd1;
        end else if (|thread_en_i) begin
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

endmodule
